// File: rtl/cache_byte_valid_ram.sv
// cache_byte_valid_ram: per-byte valid-bit store for a set-associative cache.
// Two identical RAM copies: copy A serves external reads, copy B serves the
// read half of the write pipeline's read-modify-write. A bulk-invalidate
// sweep clears every entry, and it also runs automatically after reset.
module cache_byte_valid_ram #(
  parameter int ADDR_WIDTH      = 9,
  parameter int WAY_NUM         = 4,
  parameter int WORD_BYTES      = 4,
  parameter int WORDS_PER_ENTRY = 2,
  localparam int OFS_W          = $clog2(WORDS_PER_ENTRY),
  localparam int WAY_W          = $clog2(WAY_NUM),
  localparam int ENTRY_BITS     = WORD_BYTES * WORDS_PER_ENTRY
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [WAY_W-1:0]      rd_way,
  output logic [WORD_BYTES-1:0] rd_word_valid,
  output logic [ENTRY_BITS-1:0] rd_entry_valid,
  input  logic                  wr_en,
  output logic                  wr_ready,
  input  logic [1:0]            wr_op,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WAY_W-1:0]      wr_way,
  input  logic [WORD_BYTES-1:0] wr_mask,
  input  logic [ENTRY_BITS-1:0] wr_data,
  input  logic                  flush_req,
  output logic                  flush_busy,
  output logic                  flush_done
);

  localparam int IDX_W = ADDR_WIDTH - OFS_W;
  localparam int DEPTH = 1 << IDX_W;
  localparam int ROW_W = WAY_NUM * ENTRY_BITS;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_SWEEP = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] OP_MERGE = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_NOP   = 2'b11;

  logic [ROW_W-1:0] mem_a [DEPTH];
  logic [ROW_W-1:0] mem_b [DEPTH];

  logic [1:0]            state_q, state_d;
  logic [IDX_W-1:0]      cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  s2_valid_q, s2_valid_d;
  logic [1:0]            s2_op_q, s2_op_d;
  logic [IDX_W-1:0]      s2_idx_q, s2_idx_d;
  logic [OFS_W-1:0]      s2_ofs_q, s2_ofs_d;
  logic [WAY_W-1:0]      s2_way_q, s2_way_d;
  logic [WORD_BYTES-1:0] s2_mask_q, s2_mask_d;
  logic [ENTRY_BITS-1:0] s2_data_q, s2_data_d;
  logic [ENTRY_BITS-1:0] s2_old_q, s2_old_d;

  logic [WORD_BYTES-1:0] rd_word_q, rd_word_d;
  logic [ENTRY_BITS-1:0] rd_entry_q, rd_entry_d;

  logic                  wr_fire;
  logic [IDX_W-1:0]      wr_idx;
  logic [ROW_W-1:0]      b_row;
  logic [ENTRY_BITS-1:0] s1_old;
  logic                  s2_we;
  logic [ENTRY_BITS-1:0] s2_new;
  logic                  sweep_we;
  logic [IDX_W-1:0]      rd_idx;
  logic [ROW_W-1:0]      a_row;
  logic [ENTRY_BITS-1:0] rd_entry_cur;

  assign wr_ready       = ~busy_q;
  assign wr_fire        = wr_en & ~busy_q;
  assign wr_idx         = wr_addr[ADDR_WIDTH-1:OFS_W];
  assign rd_idx         = rd_addr[ADDR_WIDTH-1:OFS_W];
  assign sweep_we       = (state_q == ST_SWEEP);
  assign s2_we          = s2_valid_q & (s2_op_q != OP_NOP);
  assign flush_busy     = busy_q;
  assign flush_done     = done_q;
  assign rd_word_valid  = rd_word_q;
  assign rd_entry_valid = rd_entry_q;

  // Commit value of the write in S2, built from the entry value captured in S1.
  always_comb begin
    s2_new = '0;
    case (s2_op_q)
      OP_MERGE: s2_new = s2_old_q | (ENTRY_BITS'(s2_mask_q) << (int'(s2_ofs_q) * WORD_BYTES));
      OP_WRITE: s2_new = s2_data_q;
      OP_CLEAR: s2_new = '0;
      default:  s2_new = s2_old_q;
    endcase
  end

  // S1: read copy B, forwarding the S2 value so back-to-back merges accumulate.
  always_comb begin
    b_row = mem_b[wr_idx];
    if (s2_we && (s2_idx_q == wr_idx) && (s2_way_q == wr_way)) begin
      s1_old = s2_new;
    end else begin
      s1_old = b_row[int'(wr_way) * ENTRY_BITS +: ENTRY_BITS];
    end
  end

  // S1 -> S2 pipeline register inputs; payload holds when no write is accepted.
  always_comb begin
    s2_valid_d = wr_fire;
    if (wr_fire) begin
      s2_op_d   = wr_op;
      s2_idx_d  = wr_idx;
      s2_ofs_d  = wr_addr[OFS_W-1:0];
      s2_way_d  = wr_way;
      s2_mask_d = wr_mask;
      s2_data_d = wr_data;
      s2_old_d  = s1_old;
    end else begin
      s2_op_d   = s2_op_q;
      s2_idx_d  = s2_idx_q;
      s2_ofs_d  = s2_ofs_q;
      s2_way_d  = s2_way_q;
      s2_mask_d = s2_mask_q;
      s2_data_d = s2_data_q;
      s2_old_d  = s2_old_q;
    end
  end

  // Read path: copy A with same-cycle commit forwarding; zero while busy, hold when idle.
  always_comb begin
    a_row = mem_a[rd_idx];
    if (s2_we && (s2_idx_q == rd_idx) && (s2_way_q == rd_way)) begin
      rd_entry_cur = s2_new;
    end else begin
      rd_entry_cur = a_row[int'(rd_way) * ENTRY_BITS +: ENTRY_BITS];
    end
    if (rd_en && busy_q) begin
      rd_entry_d = '0;
      rd_word_d  = '0;
    end else if (rd_en) begin
      rd_entry_d = rd_entry_cur;
      rd_word_d  = rd_entry_cur[int'(rd_addr[OFS_W-1:0]) * WORD_BYTES +: WORD_BYTES];
    end else begin
      rd_entry_d = rd_entry_q;
      rd_word_d  = rd_word_q;
    end
  end

  // Flush FSM: drain the write pipeline, sweep every entry once, pulse done.
  // busy/done are registered off the current state, so the DONE state is the
  // last busy cycle and the done pulse coincides with busy falling.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (flush_req) state_d = ST_DRAIN;
        else           state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (!s2_valid_q) begin
          state_d = ST_SWEEP;
          cnt_d   = '0;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_SWEEP: begin
        if (cnt_q == {IDX_W{1'b1}}) state_d = ST_DONE;
        else                        cnt_d   = cnt_q + {{(IDX_W-1){1'b0}}, 1'b1};
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = ((state_q == ST_IDLE) && flush_req) || (state_q == ST_DRAIN) || (state_q == ST_SWEEP);
    done_d = (state_q == ST_DONE);
  end

  // Control and pipeline state; reset aborts everything and restarts the sweep at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_SWEEP;
      cnt_q      <= '0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_op_q    <= OP_NOP;
      s2_idx_q   <= '0;
      s2_ofs_q   <= '0;
      s2_way_q   <= '0;
      s2_mask_q  <= '0;
      s2_data_q  <= '0;
      s2_old_q   <= '0;
      rd_word_q  <= '0;
      rd_entry_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      s2_valid_q <= s2_valid_d;
      s2_op_q    <= s2_op_d;
      s2_idx_q   <= s2_idx_d;
      s2_ofs_q   <= s2_ofs_d;
      s2_way_q   <= s2_way_d;
      s2_mask_q  <= s2_mask_d;
      s2_data_q  <= s2_data_d;
      s2_old_q   <= s2_old_d;
      rd_word_q  <= rd_word_d;
      rd_entry_q <= rd_entry_d;
    end
  end

  // Both RAM copies take identical writes; the pipeline is always empty while sweeping.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem_a[cnt_q] <= '0;
      mem_b[cnt_q] <= '0;
    end else if (s2_we) begin
      for (int w = 0; w < WAY_NUM; w++) begin
        if (s2_way_q == WAY_W'(w)) begin
          mem_a[s2_idx_q][w * ENTRY_BITS +: ENTRY_BITS] <= s2_new;
          mem_b[s2_idx_q][w * ENTRY_BITS +: ENTRY_BITS] <= s2_new;
        end
      end
    end
  end

endmodule

// File: tb/tb_cache_byte_valid_ram.sv
// Self-checking bench for cache_byte_valid_ram. The reference model is a plain
// array of entry values: a read issued in cycle K sees every write accepted
// in cycles before K, and a flush or reset empties the whole array.
module tb_cache_byte_valid_ram;

  localparam int DEPTH = 256;
  localparam int WAYS  = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rd_en;
  logic [8:0] rd_addr;
  logic [1:0] rd_way;
  logic [3:0] rd_word_valid;
  logic [7:0] rd_entry_valid;
  logic       wr_en;
  logic       wr_ready;
  logic [1:0] wr_op;
  logic [8:0] wr_addr;
  logic [1:0] wr_way;
  logic [3:0] wr_mask;
  logic [7:0] wr_data;
  logic       flush_req;
  logic       flush_busy;
  logic       flush_done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] model [DEPTH][WAYS];
  logic [7:0] exp_entry;
  logic [3:0] exp_word;

  always #5 clk = ~clk;

  cache_byte_valid_ram dut (
    .clk(clk), .rst_n(rst_n),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_way(rd_way),
    .rd_word_valid(rd_word_valid), .rd_entry_valid(rd_entry_valid),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_op(wr_op), .wr_addr(wr_addr),
    .wr_way(wr_way), .wr_mask(wr_mask), .wr_data(wr_data),
    .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done)
  );

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++)
      for (int w = 0; w < WAYS; w++)
        model[i][w] = 8'h00;
  endtask

  task automatic model_write(input int op, input int addr, input int way, input int mask, input int data);
    int idx;
    int slot;
    idx  = addr / 2;
    slot = addr % 2;
    if (op == 0)      model[idx][way] = model[idx][way] | 8'((mask << (slot * 4)) & 8'hFF);
    else if (op == 1) model[idx][way] = 8'(data);
    else if (op == 2) model[idx][way] = 8'h00;
  endtask

  // Drive one clock cycle of inputs, update expectations, sample #1 after the edge.
  task automatic do_cycle(input logic r_en, input int r_addr, input int r_way,
                          input logic w_en, input int w_op, input int w_addr,
                          input int w_way, input int w_mask, input int w_data);
    rd_en     = r_en;
    rd_addr   = 9'(r_addr);
    rd_way    = 2'(r_way);
    wr_en     = w_en;
    wr_op     = 2'(w_op);
    wr_addr   = 9'(w_addr);
    wr_way    = 2'(w_way);
    wr_mask   = 4'(w_mask);
    wr_data   = 8'(w_data);
    flush_req = 1'b0;
    if (r_en) begin
      exp_entry = model[r_addr / 2][r_way];
      exp_word  = 4'((exp_entry >> ((r_addr % 2) * 4)) & 8'h0F);
    end
    if (w_en) model_write(w_op, w_addr, w_way, w_mask, w_data);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    do_cycle(1'b0, 0, 0, 1'b0, 3, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    int n;
    int dones;
    rst_n = 1'b0;
    rd_en = 1'b0; rd_addr = 9'h000; rd_way = 2'd0;
    wr_en = 1'b0; wr_op = 2'b11; wr_addr = 9'h000; wr_way = 2'd0;
    wr_mask = 4'h0; wr_data = 8'h00; flush_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    if (flush_busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b want 1", flush_busy); end
    n_checks++;
    if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ready: got %b want 0", wr_ready); end
    n_checks++;
    if (rd_entry_valid !== 8'h00 || rd_word_valid !== 4'h0) begin
      n_fail++; $display("FAIL reset_rd: got %h/%h want 00/0", rd_entry_valid, rd_word_valid);
    end
    n_checks++;
    if (flush_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", flush_done); end
    n_checks++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n = 0; dones = 0;
    while (flush_busy === 1'b1 && n < 1000) begin
      n++;
      if (flush_done === 1'b1) dones++;
      @(posedge clk); #1;
    end
    if (n != DEPTH + 1) begin n_fail++; $display("FAIL reset_busy_len: got %0d want %0d", n, DEPTH + 1); end
    n_checks++;
    if (flush_done !== 1'b1 || dones != 0) begin
      n_fail++; $display("FAIL reset_done_pulse: got done=%b early=%0d want 1/0", flush_done, dones);
    end
    n_checks++;
    @(posedge clk); #1;
    if (flush_done !== 1'b0) begin n_fail++; $display("FAIL reset_done_width: got %b want 0", flush_done); end
    n_checks++;
    model_clear();
    for (int i = 0; i < 6; i++) begin
      do_cycle(1'b1, $urandom_range(0, 511), $urandom_range(0, 3), 1'b0, 3, 0, 0, 0, 0);
      if (rd_entry_valid !== 8'h00 || rd_word_valid !== 4'h0) begin
        n_fail++; $display("FAIL reset_swept_read: got %h/%h want 00/0", rd_entry_valid, rd_word_valid);
      end
      n_checks++;
    end
  endtask

  task automatic test_overwrite();
    do_cycle(1'b0, 0, 0, 1'b1, 1, 'h010, 2, 0, 'hA5);
    idle();
    do_cycle(1'b1, 'h010, 2, 1'b0, 3, 0, 0, 0, 0);
    if (rd_entry_valid !== 8'hA5 || rd_word_valid !== 4'h5) begin
      n_fail++; $display("FAIL overwrite_w0: got %h/%h want a5/5", rd_entry_valid, rd_word_valid);
    end
    n_checks++;
    do_cycle(1'b1, 'h011, 2, 1'b0, 3, 0, 0, 0, 0);
    if (rd_entry_valid !== 8'hA5 || rd_word_valid !== 4'hA) begin
      n_fail++; $display("FAIL overwrite_w1: got %h/%h want a5/a", rd_entry_valid, rd_word_valid);
    end
    n_checks++;
    do_cycle(1'b1, 'h010, 1, 1'b0, 3, 0, 0, 0, 0);
    if (rd_entry_valid !== 8'h00) begin
      n_fail++; $display("FAIL overwrite_other_way: got %h want 00", rd_entry_valid);
    end
    n_checks++;
  endtask

  task automatic test_back_to_back();
    do_cycle(1'b0, 0, 0, 1'b1, 0, 'h020, 1, 'h3, 0);
    do_cycle(1'b0, 0, 0, 1'b1, 0, 'h021, 1, 'hC, 0);
    idle();
    do_cycle(1'b1, 'h020, 1, 1'b0, 3, 0, 0, 0, 0);
    if (rd_entry_valid !== 8'hC3 || rd_word_valid !== 4'h3) begin
      n_fail++; $display("FAIL merge_accumulate: got %h/%h want c3/3", rd_entry_valid, rd_word_valid);
    end
    n_checks++;
  endtask

  task automatic test_same_cycle();
    do_cycle(1'b1, 'h040, 0, 1'b1, 0, 'h040, 0, 'hF, 0);
    if (rd_entry_valid !== 8'h00) begin
      n_fail++; $display("FAIL read_in_accept: got %h want 00", rd_entry_valid);
    end
    n_checks++;
    do_cycle(1'b1, 'h040, 0, 1'b0, 3, 0, 0, 0, 0);
    if (rd_entry_valid !== 8'h0F || rd_word_valid !== 4'hF) begin
      n_fail++; $display("FAIL read_in_commit: got %h/%h want 0f/f", rd_entry_valid, rd_word_valid);
    end
    n_checks++;
  endtask

  task automatic test_clear_and_nop();
    do_cycle(1'b0, 0, 0, 1'b1, 1, 'h060, 3, 0, 'hFF);
    do_cycle(1'b0, 0, 0, 1'b1, 1, 'h060, 0, 0, 'hFF);
    do_cycle(1'b0, 0, 0, 1'b1, 2, 'h060, 3, 'hF, 'hFF);
    idle();
    do_cycle(1'b1, 'h060, 3, 1'b0, 3, 0, 0, 0, 0);
    if (rd_entry_valid !== 8'h00) begin n_fail++; $display("FAIL clear_way3: got %h want 00", rd_entry_valid); end
    n_checks++;
    do_cycle(1'b1, 'h061, 0, 1'b0, 3, 0, 0, 0, 0);
    if (rd_entry_valid !== 8'hFF || rd_word_valid !== 4'hF) begin
      n_fail++; $display("FAIL clear_neighbour: got %h/%h want ff/f", rd_entry_valid, rd_word_valid);
    end
    n_checks++;
    idle();
    if (rd_entry_valid !== 8'hFF) begin n_fail++; $display("FAIL read_hold: got %h want ff", rd_entry_valid); end
    n_checks++;
    do_cycle(1'b0, 0, 0, 1'b1, 1, 'h080, 2, 0, 'h5A);
    do_cycle(1'b0, 0, 0, 1'b1, 3, 'h080, 2, 'hF, 'h00);
    idle();
    do_cycle(1'b1, 'h080, 2, 1'b0, 3, 0, 0, 0, 0);
    if (rd_entry_valid !== 8'h5A) begin n_fail++; $display("FAIL nop_op: got %h want 5a", rd_entry_valid); end
    n_checks++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      do_cycle($urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom_range(0, 3),
               $urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 15),
               $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 255));
      if (rd_entry_valid !== exp_entry || rd_word_valid !== exp_word) begin
        n_fail++; $display("FAIL random_read[%0d]: got %h/%h want %h/%h", i,
                           rd_entry_valid, rd_word_valid, exp_entry, exp_word);
      end
      n_checks++;
    end
  endtask

  task automatic test_flush();
    int n;
    int dones;
    do_cycle(1'b0, 0, 0, 1'b1, 1, 'h0C0, 0, 0, 'h3C);
    for (int i = 0; i < 4; i++)
      do_cycle(1'b0, 0, 0, 1'b1, 0, $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 15), 0);
    rd_en = 1'b0; wr_en = 1'b1; wr_op = 2'b01; wr_addr = 9'h0E0; wr_way = 2'd1; wr_data = 8'h77;
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    if (flush_busy !== 1'b1 || wr_ready !== 1'b0) begin
      n_fail++; $display("FAIL flush_busy_rise: got busy=%b ready=%b want 1/0", flush_busy, wr_ready);
    end
    n_checks++;
    rd_en = 1'b1; rd_addr = 9'h0C0; rd_way = 2'd0;
    wr_en = 1'b1; wr_op = 2'b01; wr_addr = 9'h0C0; wr_way = 2'd0; wr_data = 8'hFF;
    @(posedge clk); #1;
    rd_en = 1'b0;
    if (rd_entry_valid !== 8'h00 || rd_word_valid !== 4'h0) begin
      n_fail++; $display("FAIL read_while_busy: got %h/%h want 00/0", rd_entry_valid, rd_word_valid);
    end
    n_checks++;
    n = 0; dones = 0;
    while (flush_busy === 1'b1 && n < 1000) begin
      wr_en = 1'b1; wr_op = 2'b01; wr_addr = 9'($urandom_range(0, 15));
      wr_way = 2'($urandom_range(0, 3)); wr_data = 8'hFF;
      flush_req = (n == 20 || n == 250) ? 1'b1 : 1'b0;
      if (flush_done === 1'b1) dones++;
      @(posedge clk); #1;
      n++;
    end
    wr_en = 1'b0; flush_req = 1'b0;
    if (n >= 1000) begin n_fail++; $display("FAIL flush_timeout: got %0d cycles want <1000", n); end
    n_checks++;
    if (flush_done === 1'b1) dones++;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (flush_done === 1'b1) dones++;
    end
    if (dones != 1) begin n_fail++; $display("FAIL flush_done_count: got %0d want 1", dones); end
    n_checks++;
    model_clear();
    for (int a = 0; a < 16; a++)
      for (int w = 0; w < 4; w++) begin
        do_cycle(1'b1, a, w, 1'b0, 3, 0, 0, 0, 0);
        if (rd_entry_valid !== exp_entry) begin
          n_fail++; $display("FAIL flush_cleared[%0d/%0d]: got %h want %h", a, w, rd_entry_valid, exp_entry);
        end
        n_checks++;
      end
    do_cycle(1'b1, 'h0E0, 1, 1'b0, 3, 0, 0, 0, 0);
    if (rd_entry_valid !== 8'h00) begin n_fail++; $display("FAIL flush_inflight: got %h want 00", rd_entry_valid); end
    n_checks++;
  endtask

  task automatic test_reset_abort();
    int n;
    do_cycle(1'b0, 0, 0, 1'b1, 1, 'h100, 1, 0, 'h99);
    idle();
    do_cycle(1'b1, 'h100, 1, 1'b0, 3, 0, 0, 0, 0);
    if (rd_entry_valid !== 8'h99) begin n_fail++; $display("FAIL abort_preload: got %h want 99", rd_entry_valid); end
    n_checks++;
    rd_en = 1'b0; flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    if (flush_busy !== 1'b1 || wr_ready !== 1'b0 || rd_entry_valid !== 8'h00) begin
      n_fail++; $display("FAIL abort_async: got busy=%b ready=%b rd=%h want 1/0/00",
                         flush_busy, wr_ready, rd_entry_valid);
    end
    n_checks++;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    while (flush_busy === 1'b1 && n < 1000) begin
      n++;
      @(posedge clk); #1;
    end
    if (n != DEPTH + 1 || flush_done !== 1'b1) begin
      n_fail++; $display("FAIL abort_restart: got %0d cycles done=%b want %0d/1", n, flush_done, DEPTH + 1);
    end
    n_checks++;
    model_clear();
    do_cycle(1'b1, 'h100, 1, 1'b0, 3, 0, 0, 0, 0);
    if (rd_entry_valid !== 8'h00) begin n_fail++; $display("FAIL abort_swept: got %h want 00", rd_entry_valid); end
    n_checks++;
  endtask

  initial begin
    test_reset();
    test_overwrite();
    test_back_to_back();
    test_same_cycle();
    test_clear_and_nop();
    test_random();
    test_flush();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
